// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, SYS subop, state and ALU encodings for the 4-bit CPU
package cpu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    localparam logic [1:0] SYS_NOP  = 2'b00;
    localparam logic [1:0] SYS_JZ   = 2'b01;
    localparam logic [1:0] SYS_RSVD = 2'b10;
    localparam logic [1:0] SYS_HALT = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

    // Maps an arithmetic opcode onto the ALU encoding shared with the datapath
    function automatic logic [1:0] alu_op_of(input logic [1:0] op);
        return (op == OP_SUB) ? ALU_SUB : ALU_ADD;
    endfunction
endpackage

// File: rtl/cpu_pc.sv
// cpu_pc: program counter with sync active-low reset, jump load and wrapping increment
module cpu_pc #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_load_val,
    output logic [PC_W-1:0] o_pc
);
    logic [PC_W-1:0] r_pc;

    // Reset wins, then a taken jump, then increment (wraps modulo 2^PC_W)
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pc <= RESET_PC;
        else if (i_load)
            r_pc <= i_load_val;
        else if (i_inc)
            r_pc <= r_pc + PC_W'(1);
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the 4-bit CPU
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      INSTR,
    input  logic            INSTR_VALID,
    output logic            INSTR_READY,
    output logic [PC_W-1:0] PC,
    input  logic            ZERO,
    output logic [1:0]      SEL_A,
    output logic [1:0]      SEL_B,
    output logic [1:0]      ALU_OP,
    output logic [3:0]      IMM,
    output logic            IMM_SEL,
    output logic            WR_EN,
    output logic [1:0]      WR_SEL,
    output logic            HALTED
);
    state_t      r_state;
    logic [7:0]  r_ir;
    logic [1:0]  r_sel_a;
    logic [1:0]  r_sel_b;
    logic [1:0]  r_wr_sel;
    logic [1:0]  r_alu_op;
    logic [3:0]  r_imm;
    logic        r_imm_sel;
    logic        r_wr_en;
    logic        r_halted;

    logic [1:0]      w_op;
    logic [1:0]      w_sub;
    logic            w_decode_sys;
    logic            w_pc_load;
    logic            w_pc_inc;
    logic [PC_W-1:0] w_target;

    assign w_op         = r_ir[7:6];
    assign w_sub        = r_ir[5:4];
    assign w_decode_sys = (r_state == S_DECODE) && (w_op == OP_SYS);
    assign w_target     = PC_W'(r_ir[3:0]);
    assign w_pc_load    = w_decode_sys && (w_sub == SYS_JZ) && ZERO;
    assign w_pc_inc     = (r_state == S_WB) ||
                          (w_decode_sys && ((w_sub == SYS_NOP) || (w_sub == SYS_RSVD) ||
                                            ((w_sub == SYS_JZ) && !ZERO)));

    cpu_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pc_load),
        .i_inc      (w_pc_inc),
        .i_load_val (w_target),
        .o_pc       (PC)
    );

    // Control FSM; every control output is registered on the transition into its state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            r_wr_sel  <= '0;
            r_alu_op  <= '0;
            r_imm     <= '0;
            r_imm_sel <= 1'b0;
            r_wr_en   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (INSTR_VALID) begin
                        r_ir     <= INSTR;
                        r_sel_a  <= INSTR[3:2];
                        r_sel_b  <= INSTR[1:0];
                        r_wr_sel <= INSTR[5:4];
                        r_imm    <= INSTR[3:0];
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_ADD || w_op == OP_SUB) begin
                        r_alu_op <= alu_op_of(w_op);
                        r_state  <= S_EXEC;
                    end else if (w_op == OP_LDI) begin
                        r_wr_en   <= 1'b1;
                        r_imm_sel <= 1'b1;
                        r_state   <= S_WB;
                    end else if (w_sub == SYS_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    r_wr_en <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_wr_en   <= 1'b0;
                    r_imm_sel <= 1'b0;
                    r_state   <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign INSTR_READY = (r_state == S_FETCH);
    assign SEL_A       = r_sel_a;
    assign SEL_B       = r_sel_b;
    assign ALU_OP      = r_alu_op;
    assign IMM         = r_imm;
    assign IMM_SEL     = r_imm_sel;
    assign WR_EN       = r_wr_en;
    assign WR_SEL      = r_wr_sel;
    assign HALTED      = r_halted;
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: vector table plus writeback scoreboard and hand-written corner sequences
module tb_cpu_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] INSTR = '0;
    logic       INSTR_VALID = 1'b0;
    logic       ZERO = 1'b0;
    logic       INSTR_READY;
    logic [3:0] PC;
    logic [1:0] SEL_A, SEL_B, ALU_OP, WR_SEL;
    logic [3:0] IMM;
    logic       IMM_SEL, WR_EN, HALTED;

    always #5 clk = ~clk;

    cpu_ctrl #(.PC_W(4), .RESET_PC(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .PC(PC), .ZERO(ZERO), .SEL_A(SEL_A), .SEL_B(SEL_B),
        .ALU_OP(ALU_OP), .IMM(IMM), .IMM_SEL(IMM_SEL), .WR_EN(WR_EN), .WR_SEL(WR_SEL),
        .HALTED(HALTED)
    );

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        int         lat;
        logic       wr;
        logic [1:0] wr_sel;
        logic       imm_sel;
        logic [3:0] imm;
        logic [1:0] alu_op;
    } vec_t;

    typedef struct {
        logic [1:0] wr_sel;
        logic       imm_sel;
        logic [3:0] imm;
        logic [1:0] alu_op;
    } wb_t;

    vec_t       vt [14];
    wb_t        sbq [$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] m_pc = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding writeback expectation
    always @(negedge clk) begin
        if (WR_EN === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_wr_en", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                chk("wb_wr_sel", 32'(WR_SEL), 32'(e.wr_sel));
                chk("wb_imm_sel", 32'(IMM_SEL), 32'(e.imm_sel));
                if (e.imm_sel) chk("wb_imm", 32'(IMM), 32'(e.imm));
                else chk("wb_alu_op", 32'(ALU_OP), 32'(e.alu_op));
            end
        end
    end

    task automatic run_instr(input vec_t v);
        int cyc;
        cyc = 0;
        while (INSTR_READY !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_wait", 32'(INSTR_READY), 32'd1);
        INSTR = v.instr;
        INSTR_VALID = 1'b1;
        ZERO = v.zero;
        if (v.wr) sbq.push_back('{v.wr_sel, v.imm_sel, v.imm, v.alu_op});
        @(negedge clk);
        cyc = 1;
        chk("dec_sel_a", 32'(SEL_A), 32'(v.instr[3:2]));
        chk("dec_sel_b", 32'(SEL_B), 32'(v.instr[1:0]));
        chk("dec_wr_sel", 32'(WR_SEL), 32'(v.instr[5:4]));
        chk("dec_imm", 32'(IMM), 32'(v.instr[3:0]));
        if (v.instr[7:4] == 4'b1101 && v.zero) m_pc = v.instr[3:0];
        else if (v.instr[7:4] != 4'b1111) m_pc = m_pc + 4'd1;
        while (INSTR_READY !== 1'b1 && cyc < 20) begin
            INSTR_VALID = 1'($urandom_range(0, 1));
            INSTR = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        INSTR_VALID = 1'b0;
        chk("latency", 32'(cyc), 32'(v.lat));
        chk("pc", 32'(PC), 32'(m_pc));
    endtask

    initial begin
        vt[0]  = '{8'b00_11_01_10, 1'b0, 4, 1'b1, 2'd3, 1'b0, 4'h0, 2'b00};
        vt[1]  = '{8'b10_10_1011,  1'b0, 3, 1'b1, 2'd2, 1'b1, 4'hB, 2'b00};
        vt[2]  = '{8'b01_01_11_00, 1'b0, 4, 1'b1, 2'd1, 1'b0, 4'h0, 2'b01};
        vt[3]  = '{8'b11_00_0000,  1'b0, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[4]  = '{8'b11_10_0101,  1'b1, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[5]  = '{8'b11_01_1001,  1'b1, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[6]  = '{8'b11_01_0101,  1'b1, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[7]  = '{8'b11_01_1001,  1'b0, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[8]  = '{8'b10_00_0111,  1'b0, 3, 1'b1, 2'd0, 1'b1, 4'h7, 2'b00};
        vt[9]  = '{8'b11_01_1111,  1'b1, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[10] = '{8'b11_00_0000,  1'b0, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[11] = '{8'b00_00_11_11, 1'b1, 4, 1'b1, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[12] = '{8'b11_01_0000,  1'b0, 2, 1'b0, 2'd0, 1'b0, 4'h0, 2'b00};
        vt[13] = '{8'b01_11_10_01, 1'b0, 4, 1'b1, 2'd3, 1'b0, 4'h0, 2'b01};

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(INSTR_READY), 32'd1);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_wr_en", 32'(WR_EN), 32'd0);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_ctrl", {22'd0, SEL_A, SEL_B, WR_SEL, ALU_OP, IMM_SEL}, 32'd0);
        chk("rst_imm", 32'(IMM), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            INSTR = 8'($urandom);
            @(negedge clk);
            chk("bp_ready", 32'(INSTR_READY), 32'd1);
            chk("bp_pc", 32'(PC), 32'(m_pc));
            chk("bp_wr_en", 32'(WR_EN), 32'd0);
        end

        for (int i = 0; i < 14; i++) run_instr(vt[i]);

        INSTR = 8'b11_11_0000;
        INSTR_VALID = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            INSTR_VALID = 1'($urandom_range(0, 1));
            INSTR = 8'($urandom);
            @(negedge clk);
            chk("halt_halted", 32'(HALTED), 32'd1);
            chk("halt_ready", 32'(INSTR_READY), 32'd0);
            chk("halt_pc", 32'(PC), 32'(m_pc));
        end
        INSTR_VALID = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 4'd0;
        chk("unhalt_pc", 32'(PC), 32'd0);
        chk("unhalt_halted", 32'(HALTED), 32'd0);
        chk("unhalt_ready", 32'(INSTR_READY), 32'd1);

        INSTR = 8'b10_01_1010;
        INSTR_VALID = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        INSTR_VALID = 1'b0;
        chk("rstvalid_ready0", 32'(INSTR_READY), 32'd1);
        @(negedge clk);
        chk("rstvalid_ready1", 32'(INSTR_READY), 32'd1);
        chk("rstvalid_pc", 32'(PC), 32'd0);

        run_instr(vt[1]);
        INSTR = 8'b01_00_01_10;
        INSTR_VALID = 1'b1;
        @(negedge clk);
        INSTR_VALID = 1'b0;
        @(negedge clk);
        chk("exec_alu_op", 32'(ALU_OP), 32'd1);
        chk("exec_wr_en", 32'(WR_EN), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 4'd0;
        chk("abort_pc", 32'(PC), 32'd0);
        chk("abort_ready", 32'(INSTR_READY), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_wr_en", 32'(WR_EN), 32'd0);
            @(negedge clk);
        end

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Multi-cycle control unit for the 4-bit CPU. It fetches 8-bit instructions over a valid/ready handshake and sequences each one.
- It drives the register-file read selects (SEL_A/SEL_B), the ALU op, the writeback enable/select and the program counter.
- It sits between instruction memory and the reg_file/ALU datapath. It owns PC and all control timing.

Parameters:
- PC_W, 4, program counter width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- INSTR  input  8  instruction word. [7:6] opcode, [5:4] rd/subop, [3:2] rs_a, [1:0] rs_b; [3:0] is imm/target.
- INSTR_VALID  input  1  INSTR is valid this cycle.
- INSTR_READY  output  1  controller accepts INSTR this cycle.
- PC  output  PC_W  address of the instruction being fetched.
- ZERO  input  1  ALU zero flag, sampled in DECODE for JZ.
- SEL_A  output  2  reg_file read-port A select.
- SEL_B  output  2  reg_file read-port B select.
- ALU_OP  output  2  00 add, 01 sub; valid in EXEC and WB.
- IMM  output  4  immediate for LDI.
- IMM_SEL  output  1  1 = writeback data from IMM, 0 = from ALU.
- WR_EN  output  1  one-cycle register write strobe.
- WR_SEL  output  2  destination register.
- HALTED  output  1  controller is in HALT.

Behaviour:
- Opcodes:
  - 00 ADD rd = rs_a + rs_b
  - 01 SUB rd = rs_a - rs_b
  - 10 LDI rd = INSTR[3:0]
  - 11 SYS, decoded by [5:4]: 00 NOP, 01 JZ target = INSTR[3:0], 10 reserved (treated as NOP), 11 HALT.
- States: FETCH, DECODE, EXEC, WB, HALT. State is registered; all control outputs are registered or pure Moore decodes of state.
- FETCH:
  - INSTR_READY = 1.
  - On INSTR_VALID=1, latch INSTR into the instruction register and go to DECODE.
  - Otherwise hold; PC is stable while waiting.
- DECODE:
  - SEL_A = IR[3:2], SEL_B = IR[1:0], WR_SEL = IR[5:4], IMM = IR[3:0].
  - ADD/SUB -> EXEC.
  - LDI -> WB.
  - NOP/reserved -> FETCH with PC += 1.
  - JZ -> FETCH with PC = IR[3:0] if ZERO=1, else PC += 1.
  - HALT -> HALT.
- EXEC: ALU_OP = IR[7:6]; selects held -> WB.
- WB:
  - WR_EN = 1 for exactly this cycle; IMM_SEL = 1 only for LDI.
  - PC += 1 -> FETCH.
- HALT: HALTED = 1, INSTR_READY = 0, WR_EN = 0. Exits only via reset.
- Latency (VALID already high): ALU op 4 cycles, LDI 3, NOP/JZ 2. Next INSTR_READY is asserted in the cycle after WB/DECODE.
- INSTR_VALID outside FETCH is ignored; INSTR is not sampled.
- PC wraps from 2^PC_W-1 to 0. JZ target is zero-extended to PC_W.
- Reset values (the cycle after rst_n is sampled low):
  - state = FETCH, PC = RESET_PC, IR = 0.
  - SEL_A = SEL_B = WR_SEL = 0, ALU_OP = 0, IMM = 0.
  - IMM_SEL = 0, WR_EN = 0, HALTED = 0.
  - INSTR_READY = 1 once state = FETCH.
- Reset mid-operation, in any state including WB and HALT: the next edge aborts. No WR_EN is issued for the aborted instruction and PC = RESET_PC.
- rst_n overrides INSTR_VALID in the same cycle; the instruction is not latched.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_LDI/OP_SYS
  - SYS subop constants SYS_NOP/SYS_JZ/SYS_HALT
  - state encoding localparams
  - ALU_OP encodings, so the ALU uses the same values
- One natural sub-module, cpu_pc: PC_W-bit register with sync active-low reset to RESET_PC, load (JZ taken) and increment; load has priority over increment.

Test Plan:
- Reset then ADD: INSTR=8'b00_11_01_10 with VALID high -> DECODE SEL_A=1, SEL_B=2. EXEC ALU_OP=00. WB WR_EN=1 for one cycle with WR_SEL=3, IMM_SEL=0. PC goes 0 -> 1. INSTR_READY high again 4 cycles after accept.
- LDI: INSTR=8'b10_10_1011 -> WB in 3 cycles, WR_SEL=2, IMM=4'hB, IMM_SEL=1, WR_EN pulse of exactly 1 cycle.
- JZ: at PC=5 with INSTR=8'b11_01_1001:
  - ZERO=1 -> next PC=9.
  - Repeat with ZERO=0 -> PC=6.
  - No WR_EN in either case.
- Backpressure: hold INSTR_VALID=0 for 10 cycles in FETCH -> INSTR_READY stays 1, PC and all outputs stable. Toggling VALID during EXEC has no effect.
- Wrap and HALT:
  - NOP at PC=15 -> PC=0.
  - HALT (8'b11_11_0000) -> HALTED=1, INSTR_READY=0 for 20 cycles.
  - rst_n low for 1 cycle -> PC=RESET_PC, HALTED=0.
- Reset in WB: assert rst_n=0 in the cycle after entering EXEC of a SUB -> WR_EN never asserted, PC=0, state FETCH.
